// File: rtl/lsu_store_buffer.sv
// Store buffer: FIFO of lane-aligned stores presented to a byte/word register port.
// Optional misaligned-store rejection with err pulse: LSU_STORE_MISALIGN_CHK_EN.
module lsu_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_data,
    input  logic [1:0]                   req_size,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [31:0]                  wr_addr,
    output logic [31:0]                  wr_data,
    output logic [3:0]                   wr_be,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count_q;

    logic          push;
    logic          pop;
    logic          enq;
    logic [31:0]   align_data;
    logic [3:0]    align_be;

    assign req_ready = (count_q != CW'(DEPTH)) && !rst;
    assign wr_valid  = (count_q != '0);
    assign push      = req_valid && req_ready;
    assign pop       = wr_valid && wr_ready;
    assign count     = count_q;
    assign wr_addr   = {addr_q[rptr], 2'b00};
    assign wr_data   = data_q[rptr];
    assign wr_be     = be_q[rptr];

    // Misaligned low address bits are simply ignored when the checker is absent.
    always_comb begin
        align_data = '0;
        align_be   = '0;
        case (req_size)
            2'b00: begin
                align_be   = 4'b0001 << req_addr[1:0];
                align_data = {24'h0, req_data[7:0]} << {req_addr[1:0], 3'b000};
            end
            2'b01: begin
                align_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                align_data = req_addr[1] ? {req_data[15:0], 16'h0} : {16'h0, req_data[15:0]};
            end
            default: begin
                align_be   = 4'b1111;
                align_data = req_data;
            end
        endcase
    end

`ifdef LSU_STORE_MISALIGN_CHK_EN
    logic misaligned;
    logic err_q;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            default: misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    // Rejected requests still handshake; they just never reach the queue.
    assign enq = push && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= push && misaligned;
        end
    end

    assign err = err_q;
`else
    assign enq = push;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wptr] <= req_addr[31:2];
            data_q[wptr] <= align_data;
            be_q[wptr]   <= align_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({enq, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: alignment table plus full, wrap, reset and misalign sequences.
module tb_lsu_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [2:0]  count;
    logic        err;

    int passed = 0;
    int total  = 0;

    lsu_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    initial begin
        vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 2'b00, 32'h0000_1000, 32'hAB00_0000, 4'b1000};
        vecs[1] = '{32'h0000_2002, 32'h0000_1234, 2'b01, 32'h0000_2000, 32'h1234_0000, 4'b1100};
        vecs[2] = '{32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111};
        vecs[3] = '{32'h0000_5001, 32'hFFFF_FF5A, 2'b00, 32'h0000_5000, 32'h0000_5A00, 4'b0010};
        vecs[4] = '{32'h0000_6000, 32'hCAFE_1234, 2'b01, 32'h0000_6000, 32'h0000_1234, 4'b0011};
        vecs[5] = '{32'h0000_7004, 32'h0102_0304, 2'b11, 32'h0000_7004, 32'h0102_0304, 4'b1111};
        vecs[6] = '{32'h0000_9000, 32'h1234_5677, 2'b00, 32'h0000_9000, 32'h0000_0077, 4'b0001};

        rst = 1'b1;
        wr_ready = 1'b0;
        set_req(1'b1, 32'h0000_0040, 32'h5555_5555, 2'b10);
        step();
        step();
        check("rst_count", 32'(count), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        set_req(1'b0, 0, 0, 2'b00);
        step();
        check("rst_no_push", 32'(count), 0);
        check("post_rst_req_ready", 32'(req_ready), 1);

        // Alignment table: push with downstream stalled, inspect head, then pop.
        for (int i = 0; i < 7; i++) begin
            set_req(1'b1, vecs[i].addr, vecs[i].data, vecs[i].size);
            check($sformatf("v%0d_no_bypass", i), 32'(wr_valid), 0);
            step();
            set_req(1'b0, 0, 0, 2'b00);
            check($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 1);
            check($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].exp_data);
            check($sformatf("v%0d_wr_be", i), 32'(wr_be), 32'(vecs[i].exp_be));
            check($sformatf("v%0d_count", i), 32'(count), 1);
            wr_ready = 1'b1;
            step();
            wr_ready = 1'b0;
            check($sformatf("v%0d_popped", i), 32'(count), 0);
        end

        // Fill to DEPTH with downstream stalled.
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 32'h100 * (i + 1), 32'h11 * (i + 1), 2'b10);
            step();
        end
        check("full_count", 32'(count), 4);
        check("full_req_ready", 32'(req_ready), 0);
        set_req(1'b1, 32'h0000_0500, 32'h0000_0055, 2'b10);
        step();
        check("full_held", 32'(count), 4);
        check("full_head", wr_data, 32'h11);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        check("full_pop_no_push", 32'(count), 3);
        check("full_ready_again", 32'(req_ready), 1);
        step();
        set_req(1'b0, 0, 0, 2'b00);
        check("full_fifth_pushed", 32'(count), 4);
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("order%0d_data", i), wr_data, 32'h11 * (i + 2));
            check($sformatf("order%0d_addr", i), wr_addr, (i < 3) ? 32'h100 * (i + 2) : 32'h500);
            step();
        end
        wr_ready = 1'b0;
        check("drained", 32'(count), 0);

        // Steady push/pop through more than two pointer wraps.
        set_req(1'b1, 32'h0000_0000, 32'h0000_0100, 2'b10);
        step();
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(1'b1, 32'h0000_0000, 32'h101 + i, 2'b10);
            check($sformatf("wrap%0d_data", i), wr_data, 32'h100 + i);
            check($sformatf("wrap%0d_count", i), 32'(count), 1);
            step();
        end
        set_req(1'b0, 0, 0, 2'b00);
        wr_ready = 1'b0;
        check("wrap_last_data", wr_data, 32'h10A);
        check("wrap_last_count", 32'(count), 1);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        check("wrap_drained", 32'(count), 0);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 32'h0000_0A00, 32'hA0 + i, 2'b10);
            step();
        end
        set_req(1'b0, 0, 0, 2'b00);
        check("mid_count", 32'(count), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_wr_valid", 32'(wr_valid), 0);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        check("post_rst_wr_valid", 32'(wr_valid), 0);
        check("post_rst_count", 32'(count), 0);

        // Misaligned word store.
        set_req(1'b1, 32'h0000_3001, 32'h89AB_CDEF, 2'b10);
        check("mis_ready", 32'(req_ready), 1);
        step();
        set_req(1'b0, 0, 0, 2'b00);
`ifdef LSU_STORE_MISALIGN_CHK_EN
        check("mis_err_pulse", 32'(err), 1);
        check("mis_count", 32'(count), 0);
        check("mis_wr_valid", 32'(wr_valid), 0);
        step();
        check("mis_err_one_cycle", 32'(err), 0);
        check("mis_count_after", 32'(count), 0);
`else
        check("mis_err_tied", 32'(err), 0);
        check("mis_count", 32'(count), 1);
        check("mis_wr_addr", wr_addr, 32'h0000_3000);
        check("mis_wr_be", 32'(wr_be), 32'hF);
        check("mis_wr_data", wr_data, 32'h89AB_CDEF);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        set_req(1'b1, 32'h0000_8003, 32'h0000_BEEF, 2'b01);
        step();
        set_req(1'b0, 0, 0, 2'b00);
        check("mis_half_addr", wr_addr, 32'h0000_8000);
        check("mis_half_data", wr_data, 32'hBEEF_0000);
        check("mis_half_be", 32'(wr_be), 32'hC);
        check("mis_half_err", 32'(err), 0);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        check("mis_half_drained", 32'(count), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
